vga_color_mapper: RTL
=====================

# vga_color_mapper

Parametrised pixel colour stage feeding the VGA DAC outputs. It replaces the fixed four-colour game mapping with a run-time-writable palette, supports configurable channel and index widths, and adds a frame-synchronous blink mode for one palette index. It sits between the game block / background ROM and the DAC pins, on the 25 MHz pixel clock, with a fixed two-cycle pipeline.

## Interface
Parameters:
- COLOR_BITS, 10, width of each of red/green/blue.
- INDEX_BITS, 2, width of game_data and the palette address; palette has 2^INDEX_BITS entries.
- BLINK_FRAMES, 30, frames per blink half-period; must be ≥1.

Ports:
- clock_25  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- display_area  in  1  high while the current pixel is visible.
- game_enable  in  1  high: pixel comes from game_data via the palette; low: from datarom.
- game_data  in  INDEX_BITS  palette index for the current pixel.
- datarom  in  1  background ROM bit: 1 = white, 0 = black.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- pal_wr_en  in  1  palette write strobe.
- pal_wr_addr  in  INDEX_BITS  palette entry to write.
- pal_wr_data  in  3*COLOR_BITS  {red, green, blue} for the entry.
- blink_en  in  1  enables blinking of blink_index.
- blink_index  in  INDEX_BITS  palette index that blinks.
- red, green, blue  out  COLOR_BITS each  registered DAC values.
- pixel_valid  out  1  display_area delayed to align with the colour outputs.

## Operation
- Stage 1 registers display_area, game_enable, game_data and datarom. No other logic is in this stage.
- Stage 2 computes the outputs from the stage-1 registers, in this priority order:
  - stage-1 display_area = 0 → all channels 0.
  - else stage-1 game_enable = 1 and blink is hiding that index → all channels 0.
  - else stage-1 game_enable = 1 → palette[stage-1 game_data].
  - else stage-1 datarom = 1 → all channels full scale ({COLOR_BITS{1'b1}}).
  - else → all channels 0.
- The blink is hiding an index when blink_en = 1, blink_phase = 0 and stage-1 game_data == blink_index.
- Palette writes:
  - When pal_wr_en = 1, the addressed entry updates at that edge.
  - The stage-2 lookup in that same cycle uses the old contents (no bypass).
  - There is no handshake; one write can be accepted per cycle.
- Blink counter:
  - frame_cnt counts frame_start pulses, 0..BLINK_FRAMES-1.
  - When a frame_start arrives with frame_cnt = BLINK_FRAMES-1, frame_cnt wraps to 0 and blink_phase toggles.
  - frame_cnt and blink_phase run whether or not blink_en is set.
  - frame_cnt width is $clog2(BLINK_FRAMES), minimum 1 bit.
- Reset values (reset_n = 0 at an edge):
  - red, green and blue = 0; pixel_valid = 0; all stage-1 registers = 0.
  - frame_cnt = 0; blink_phase = 1 (visible).
  - Palette defaults, with F = all ones and 0 = zero: entry 0 black (0,0,0); entry 1 green (0,F,0); entry 2 red (F,0,0); entry 3 white (F,F,F); entries ≥4 black.
  - If INDEX_BITS = 1, only entries 0 and 1 exist.
- Simultaneous events:
  - Reset beats frame_start and pal_wr_en.
  - A palette write to the entry being displayed takes effect on the next pixel.
  - A change to blink_en or blink_index is sampled combinationally in stage 2.

## Timing
- Latency is 2 cycles from the inputs to red/green/blue and pixel_valid; throughput is one pixel per cycle.
- If reset is released at edge N, valid pixel data appears from edge N+2.
- A palette write at edge N is visible on the outputs for pixels whose stage-1 capture is at edge ≥N, i.e. outputs at edge ≥N+1.
- A blink_phase toggle at edge N affects outputs from edge N+1.

## Structure
- Add INDEX_BITS, COLOR_BITS and BLINK_FRAMES defaults, plus the BLACK/GREEN/RED/WHITE index constants, to global_parameters.v.
- Sub-module vga_palette_regs contains the 2^INDEX_BITS × 3*COLOR_BITS register file with reset defaults, the synchronous write port and the asynchronous read port.
- Top-level vga_color_mapper contains the pipeline, the mux, the blink counter and its phase.

## Test plan
- Reset, then game_enable=1, display_area=1, game_data=2 → two cycles later red=3FF, green=0, blue=0, pixel_valid=1.
- Write pal_wr_addr=1, pal_wr_data={10'h155,10'h0AA,10'h3FF} while game_data=1 is streaming → the output at the write-cycle edge is still green (0,3FF,0); the following pixel is (155,0AA,3FF).
- BLINK_FRAMES=2, blink_en=1, blink_index=3, steady index 3 → white for 2 frame_start pulses, black for 2, white again; index 0 is unaffected.
- display_area=0 with game_enable=1 and game_data=3 → outputs 0 and pixel_valid=0; with game_enable=0 and datarom=1 inside the display area → 3FF on all channels.
- Assert reset_n=0 mid-line after a palette write and blink toggle → next edge all outputs 0, palette back to defaults, blink_phase=1, frame_cnt=0.
- Assert frame_start in the same cycle as reset → frame_cnt stays 0 after reset.

Source files
------------

// File: rtl/vga_color_mapper_pkg.sv
// Shared defaults, palette index names and reset colour helpers for the VGA colour stage.
package vga_color_mapper_pkg;

  localparam int unsigned DEF_INDEX_BITS   = 2;
  localparam int unsigned DEF_COLOR_BITS   = 10;
  localparam int unsigned DEF_BLINK_FRAMES = 30;

  localparam int unsigned IDX_BLACK = 0;
  localparam int unsigned IDX_GREEN = 1;
  localparam int unsigned IDX_RED   = 2;
  localparam int unsigned IDX_WHITE = 3;

  // Which source drives the DAC registers for the pixel in stage 2.
  typedef enum logic [1:0] {
    SRC_BLANK,
    SRC_PALETTE,
    SRC_ROM_WHITE
  } pix_src_e;

  // Full-scale mask {red, green, blue} of a palette entry after reset.
  function automatic logic [2:0] default_mask(input int unsigned idx);
    case (idx)
      IDX_GREEN: default_mask = 3'b010;
      IDX_RED:   default_mask = 3'b100;
      IDX_WHITE: default_mask = 3'b111;
      default:   default_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vga_color_mapper_palette_regs.sv
// Run-time writable palette: 2^INDEX_BITS entries of {red, green, blue},
// synchronous write, asynchronous read, reset to the legacy game colours.
module vga_palette_regs
  import vga_color_mapper_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                    clock_25,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [INDEX_BITS-1:0]   wr_addr,
  input  logic [3*COLOR_BITS-1:0] wr_data,
  input  logic [INDEX_BITS-1:0]   rd_addr,
  output logic [3*COLOR_BITS-1:0] rd_data
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [3*COLOR_BITS-1:0] mem [ENTRIES];

  function automatic logic [3*COLOR_BITS-1:0] default_entry(input int unsigned idx);
    logic [2:0] m;
    m = default_mask(idx);
    default_entry = {{COLOR_BITS{m[2]}}, {COLOR_BITS{m[1]}}, {COLOR_BITS{m[0]}}};
  endfunction

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= default_entry(i);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vga_color_mapper.sv
// Two-stage pixel colour pipeline: input capture, then palette / ROM / blink
// selection into registered DAC outputs. Frame-counted blink for one index.
module vga_color_mapper
  import vga_color_mapper_pkg::*;
#(
  parameter int unsigned COLOR_BITS   = DEF_COLOR_BITS,
  parameter int unsigned INDEX_BITS   = DEF_INDEX_BITS,
  parameter int unsigned BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic                    clock_25,
  input  logic                    reset_n,
  input  logic                    display_area,
  input  logic                    game_enable,
  input  logic [INDEX_BITS-1:0]   game_data,
  input  logic                    datarom,
  input  logic                    frame_start,
  input  logic                    pal_wr_en,
  input  logic [INDEX_BITS-1:0]   pal_wr_addr,
  input  logic [3*COLOR_BITS-1:0] pal_wr_data,
  input  logic                    blink_en,
  input  logic [INDEX_BITS-1:0]   blink_index,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    pixel_valid
);

  localparam int unsigned CNT_BITS = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BLINK_FRAMES - 1);

  logic                    s1_display_area;
  logic                    s1_game_enable;
  logic [INDEX_BITS-1:0]   s1_game_data;
  logic                    s1_datarom;

  logic [CNT_BITS-1:0]     frame_cnt;
  logic                    blink_phase;

  logic [3*COLOR_BITS-1:0] pal_rd_data;
  logic                    blink_hide;
  pix_src_e                pix_src;
  logic [3*COLOR_BITS-1:0] pix_next;

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      s1_display_area <= 1'b0;
      s1_game_enable  <= 1'b0;
      s1_game_data    <= '0;
      s1_datarom      <= 1'b0;
    end else begin
      s1_display_area <= display_area;
      s1_game_enable  <= game_enable;
      s1_game_data    <= game_data;
      s1_datarom      <= datarom;
    end
  end

  // Runs regardless of blink_en so enabling blink mid-stream stays frame-aligned.
  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_start) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  vga_palette_regs #(
    .INDEX_BITS (INDEX_BITS),
    .COLOR_BITS (COLOR_BITS)
  ) u_palette (
    .clock_25 (clock_25),
    .reset_n  (reset_n),
    .wr_en    (pal_wr_en),
    .wr_addr  (pal_wr_addr),
    .wr_data  (pal_wr_data),
    .rd_addr  (s1_game_data),
    .rd_data  (pal_rd_data)
  );

  assign blink_hide = blink_en && !blink_phase && (s1_game_data == blink_index);

  always_comb begin
    pix_src = SRC_BLANK;
    if (s1_display_area) begin
      if (s1_game_enable) begin
        pix_src = blink_hide ? SRC_BLANK : SRC_PALETTE;
      end else if (s1_datarom) begin
        pix_src = SRC_ROM_WHITE;
      end
    end
  end

  always_comb begin
    pix_next = '0;
    case (pix_src)
      SRC_PALETTE:   pix_next = pal_rd_data;
      SRC_ROM_WHITE: pix_next = '1;
      default:       pix_next = '0;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel_valid <= 1'b0;
    end else begin
      red         <= pix_next[3*COLOR_BITS-1:2*COLOR_BITS];
      green       <= pix_next[2*COLOR_BITS-1:COLOR_BITS];
      blue        <= pix_next[COLOR_BITS-1:0];
      pixel_valid <= s1_display_area;
    end
  end

endmodule
